// File: rtl/vec_engine.sv
// vec_engine: streams vectors A and B from two BRAMs LANES elements per cycle.
// Ops 5/6 reduce to a 32-bit saturating Manhattan / Euclidean distance;
// ops 3/4 emit element-wise sum / average under ready/valid handshaking.
// Optional feature macro: VEC_SQRT_EN (16-step restoring integer square root
// applied to the Euclidean result).
module vec_engine #(
  parameter  int NBITS   = 8,
  parameter  int BR_SIZE = 1024,
  parameter  int LANES   = 4,
  localparam int D       = BR_SIZE / LANES,
  localparam int AW      = (D > 1) ? $clog2(D) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             operation,
  output logic [AW-1:0]          rd_addr,
  input  logic [NBITS*LANES-1:0] a_data,
  input  logic [NBITS*LANES-1:0] b_data,
  output logic [31:0]            res_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = 2 * NBITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
`ifdef VEC_SQRT_EN
    S_SQRT,
`endif
    S_OUT,
    S_SLOAD,
    S_SEMIT
  } state_e;

  typedef enum logic [2:0] {
    OP_SUM = 3'd3,
    OP_AVG = 3'd4,
    OP_MAN = 3'd5,
    OP_EUC = 3'd6
  } op_e;

  state_e              r_state, w_state_nxt;
  op_e                 r_op;
  logic [AW-1:0]       r_rd_addr;
  logic [31:0]         r_res_data;
  logic                r_res_valid;
  logic [31:0]         r_acc;
  logic                r_bad;
  logic                r_v_rd;
  logic                r_v_s1;
  logic [LW-1:0]       r_lane;
  logic                r_sload_ph;
  logic [NBITS-1:0]    r_a_lane [LANES];
  logic [NBITS-1:0]    r_b_lane [LANES];
  logic [PW-1:0]       r_s1     [LANES];

  logic [NBITS-1:0]    w_a_in   [LANES];
  logic [NBITS-1:0]    w_b_in   [LANES];
  logic [NBITS-1:0]    w_diff   [LANES];
  logic [PW-1:0]       w_sq     [LANES];
  logic [63:0]         w_tree;
  logic [63:0]         w_acc_sum;
  logic [31:0]         w_acc_nxt;
  logic                w_op_scalar, w_op_stream;
  logic                w_last_word, w_last_lane, w_drained, w_hs;
  logic [LW-1:0]       w_lane_nxt;

`ifdef VEC_SQRT_EN
  logic [31:0] r_sq_rad;
  logic [17:0] r_sq_rem;
  logic [15:0] r_sq_root;
  logic [3:0]  r_sq_cnt;
  logic [19:0] w_sq_sh, w_sq_trial;
  logic        w_sq_ge;
  logic [15:0] w_sq_root_nxt;

  // One restoring square-root step: bring down the next radicand bit pair.
  always_comb begin
    w_sq_sh       = {r_sq_rem, r_sq_rad[31:30]};
    w_sq_trial    = {2'b00, r_sq_root, 2'b01};
    w_sq_ge       = (w_sq_sh >= w_sq_trial);
    w_sq_root_nxt = {r_sq_root[14:0], w_sq_ge};
  end
`endif

  function automatic logic [31:0] f_elem(input logic [NBITS-1:0] a,
                                         input logic [NBITS-1:0] b,
                                         input logic avg);
    logic [NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (avg) s = s >> 1;
    return 32'(s);
  endfunction

  // Lane unpacking, per-lane distance terms, adder tree and saturating add.
  always_comb begin
    w_tree = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_a_in[i] = a_data[i*NBITS +: NBITS];
      w_b_in[i] = b_data[i*NBITS +: NBITS];
      w_diff[i] = (w_a_in[i] >= w_b_in[i]) ? (w_a_in[i] - w_b_in[i])
                                           : (w_b_in[i] - w_a_in[i]);
      w_sq[i]   = PW'(w_diff[i]) * PW'(w_diff[i]);
      w_tree    = w_tree + 64'(r_s1[i]);
    end
    w_acc_sum = {32'b0, r_acc} + w_tree;
    w_acc_nxt = (|w_acc_sum[63:32]) ? '1 : w_acc_sum[31:0];
  end

  assign w_op_scalar = (operation == OP_MAN) || (operation == OP_EUC);
  assign w_op_stream = (operation == OP_SUM) || (operation == OP_AVG);
  assign w_last_word = (r_rd_addr == AW'(D - 1));
  assign w_last_lane = (r_lane == LW'(LANES - 1));
  assign w_lane_nxt  = r_lane + 1'b1;
  assign w_drained   = !r_v_rd && !r_v_s1;
  assign w_hs        = r_res_valid && res_ready;

  assign rd_addr   = r_rd_addr;
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake-dependent outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = r_bad;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_op_scalar)      w_state_nxt = S_FETCH;
          else if (w_op_stream) w_state_nxt = S_SLOAD;
        end
      end
      S_FETCH: if (w_last_word) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
`ifdef VEC_SQRT_EN
        if (w_drained) w_state_nxt = (r_op == OP_EUC) ? S_SQRT : S_OUT;
`else
        if (w_drained) w_state_nxt = S_OUT;
`endif
      end
`ifdef VEC_SQRT_EN
      S_SQRT: if (r_sq_cnt == 4'd15) w_state_nxt = S_OUT;
`endif
      S_OUT: begin
        if (w_hs) begin
          w_state_nxt = S_IDLE;
          done        = 1'b1;
        end
      end
      S_SLOAD: if (r_sload_ph) w_state_nxt = S_SEMIT;
      S_SEMIT: begin
        if (w_hs && w_last_lane) begin
          w_state_nxt = w_last_word ? S_IDLE : S_SLOAD;
          done        = w_last_word;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage 1: per-lane |a-b| or (a-b)^2 of the word returned this cycle.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++)
      r_s1[i] <= (r_op == OP_EUC) ? w_sq[i] : PW'(w_diff[i]);
  end

  // Word capture for the element-wise stream.
  always_ff @(posedge clk) begin
    if (r_state == S_SLOAD && r_sload_ph) begin
      r_a_lane <= w_a_in;
      r_b_lane <= w_b_in;
    end
  end

  // Control/datapath registers: address, accumulator, result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_SUM;
      r_rd_addr   <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_acc       <= '0;
      r_bad       <= 1'b0;
      r_v_rd      <= 1'b0;
      r_v_s1      <= 1'b0;
      r_lane      <= '0;
      r_sload_ph  <= 1'b0;
`ifdef VEC_SQRT_EN
      r_sq_rad    <= '0;
      r_sq_rem    <= '0;
      r_sq_root   <= '0;
      r_sq_cnt    <= '0;
`endif
    end else begin
      r_bad  <= 1'b0;
      r_v_rd <= (r_state == S_FETCH);
      r_v_s1 <= r_v_rd;
      if (r_v_s1) r_acc <= w_acc_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_op_scalar || w_op_stream) begin
              r_op       <= op_e'(operation);
              r_rd_addr  <= '0;
              r_acc      <= '0;
              r_lane     <= '0;
              r_sload_ph <= 1'b0;
            end else begin
              r_bad <= 1'b1;
            end
          end
        end
        S_FETCH: if (!w_last_word) r_rd_addr <= r_rd_addr + 1'b1;
        S_DRAIN: begin
          if (w_drained) begin
`ifdef VEC_SQRT_EN
            if (r_op == OP_EUC) begin
              r_sq_rad  <= r_acc;
              r_sq_rem  <= '0;
              r_sq_root <= '0;
              r_sq_cnt  <= '0;
            end else
`endif
            begin
              r_res_data  <= r_acc;
              r_res_valid <= 1'b1;
            end
          end
        end
`ifdef VEC_SQRT_EN
        S_SQRT: begin
          r_sq_rad  <= {r_sq_rad[29:0], 2'b00};
          r_sq_rem  <= 18'(w_sq_ge ? (w_sq_sh - w_sq_trial) : w_sq_sh);
          r_sq_root <= w_sq_root_nxt;
          r_sq_cnt  <= r_sq_cnt + 1'b1;
          if (r_sq_cnt == 4'd15) begin
            r_res_data  <= {16'b0, w_sq_root_nxt};
            r_res_valid <= 1'b1;
          end
        end
`endif
        S_OUT: if (res_ready) r_res_valid <= 1'b0;
        S_SLOAD: begin
          // Phase 0 presents the address, phase 1 sees the returned word.
          r_sload_ph <= ~r_sload_ph;
          if (r_sload_ph) begin
            r_res_data  <= f_elem(w_a_in[0], w_b_in[0], r_op == OP_AVG);
            r_res_valid <= 1'b1;
            r_lane      <= '0;
          end
        end
        S_SEMIT: begin
          if (res_ready) begin
            if (w_last_lane) begin
              r_res_valid <= 1'b0;
              if (!w_last_word) r_rd_addr <= r_rd_addr + 1'b1;
            end else begin
              r_lane     <= w_lane_nxt;
              r_res_data <= f_elem(r_a_lane[w_lane_nxt], r_b_lane[w_lane_nxt],
                                   r_op == OP_AVG);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
